// File: rtl/nios2_oci_trace_packer.sv
// Trace record packer: narrow OCI capture records are packed into buffer words,
// queued in a small FIFO and drained over valid/ready; test end flushes and drains.
module nios2_oci_trace_packer #(
  parameter  int REC_W      = 3,
  parameter  int RECS       = 10,
  parameter  int CNT_W      = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int BUF_W      = REC_W * RECS,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rec_valid,
  input  logic [REC_W-1:0] rec_data,
  input  logic             test_ending,
  input  logic             out_ready,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             out_valid,
  output logic [BUF_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  output logic             test_has_ended
);

  // state   | meaning
  // S_RUN   | capturing records
  // S_FLUSH | one cycle: push any partial word
  // S_DRAIN | capture stopped, waiting for FIFO to empty
  // S_ENDED | done, sticky until reset
  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN, S_ENDED} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  state_t state, state_nxt;
  logic   capture_en, flush_en;

  logic             accept, word_done, push, pop, full, wr_en, drop;
  logic [BUF_W-1:0] buf_ins, push_data;
  logic [CNT_W-1:0] push_cnt;

  logic [BUF_W-1:0] mem_data [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_cnt  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (test_ending) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_level == '0) state_nxt = S_ENDED;
      S_ENDED: state_nxt = S_ENDED;
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    capture_en     = 1'b0;
    flush_en       = 1'b0;
    test_has_ended = 1'b0;
    case (state)
      S_RUN:   capture_en     = 1'b1;
      S_FLUSH: flush_en       = 1'b1;
      S_ENDED: test_has_ended = 1'b1;
      default: ;
    endcase
  end

  // rec_data is only sampled through accept, so idle-cycle garbage never lands in the buffer
  always_comb begin
    accept    = rec_valid & capture_en;
    word_done = accept && (dct_count == CNT_W'(RECS - 1));
    buf_ins   = dct_buffer;
    buf_ins[int'(dct_count) * REC_W +: REC_W] = rec_data;
    push      = word_done | (flush_en && (dct_count != '0));
    push_data = word_done ? buf_ins : dct_buffer;
    push_cnt  = word_done ? CNT_W'(RECS) : dct_count;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (word_done || flush_en) begin
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (accept) begin
      dct_buffer <= buf_ins;
      dct_count  <= dct_count + CNT_W'(1);
    end
  end

  // A pop frees the head slot this cycle, so a push into a full FIFO still lands
  always_comb begin
    full      = (fifo_level == LVL_W'(FIFO_DEPTH));
    out_valid = (fifo_level != '0);
    pop       = out_valid & out_ready;
    wr_en     = push & (~full | pop);
    drop      = push & full & ~pop;
    out_data  = out_valid ? mem_data[rd_ptr] : '0;
    out_count = out_valid ? mem_cnt[rd_ptr]  : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= push_data;
      mem_cnt[wr_ptr]  <= push_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: ;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nios2_oci_trace_packer.sv
// Directed bench for nios2_oci_trace_packer: a scoreboard queue holds the words
// expected at the sink; a negedge monitor compares every popped word.
module tb_nios2_oci_trace_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        rec_valid;
  logic [2:0]  rec_data;
  logic        test_ending;
  logic        out_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        out_valid;
  logic [29:0] out_data;
  logic [3:0]  out_count;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        test_has_ended;

  int vectors     = 0;
  int miscompares = 0;
  logic [33:0] sb [$];

  nios2_oci_trace_packer dut (
    .clk(clk), .reset(reset), .rec_valid(rec_valid), .rec_data(rec_data),
    .test_ending(test_ending), .out_ready(out_ready), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .out_valid(out_valid), .out_data(out_data),
    .out_count(out_count), .fifo_level(fifo_level), .overflow(overflow),
    .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", {out_count, out_data}, 34'h0);
      end else begin
        logic [33:0] e;
        e = sb.pop_front();
        chk("pop_data",  34'(out_data),  34'(e[29:0]));
        chk("pop_count", 34'(out_count), 34'(e[33:30]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [29:0] word_of(input int base);
    logic [29:0] w;
    for (int i = 0; i < 10; i++) w[i*3 +: 3] = 3'((base + i) % 8);
    return w;
  endfunction

  task automatic idle_inputs();
    rec_valid   = 1'b0;
    rec_data    = 3'($urandom_range(0, 7));
    test_ending = 1'b0;
  endtask

  task automatic send_rec(input logic [2:0] d, input logic te);
    rec_valid   = 1'b1;
    rec_data    = d;
    test_ending = te;
    tick();
    idle_inputs();
  endtask

  task automatic send_word(input int base);
    for (int i = 0; i < 10; i++) send_rec(3'((base + i) % 8), 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_zero"}, {dct_buffer, dct_count, out_valid, out_data, out_count,
                         fifo_level, overflow, test_has_ended} == '0 ? 34'd0 : 34'd1, 34'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1'b0;
    reset = 1'b1;
    #2;
    chk_all_zero("reset");
    sb.delete();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_ended(input string tag, input int max);
    int n = 0;
    while (!test_has_ended && n < max) begin tick(); n++; end
    chk(tag, 34'(test_has_ended), 34'd1);
  endtask

  task automatic wait_empty(input string tag, input int max);
    int n = 0;
    while (fifo_level != 0 && n < max) begin tick(); n++; end
    chk(tag, 34'(fifo_level), 34'd0);
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    out_ready = 1'b0;
    #3;
    do_reset();

    // 1: fill one word
    for (int i = 0; i < 9; i++) send_rec(3'(i % 8), 1'b0);
    chk("t1_cnt9", 34'(dct_count), 34'd9);
    chk("t1_buf9", 34'(dct_buffer), 34'(30'o076543210));
    sb.push_back({4'd10, 30'o1076543210});
    send_rec(3'd1, 1'b0);
    chk("t1_cnt_clr", 34'(dct_count), 34'd0);
    chk("t1_buf_clr", 34'(dct_buffer), 34'd0);
    chk("t1_level", 34'(fifo_level), 34'd1);
    chk("t1_data", 34'(out_data), 34'(30'o1076543210));
    chk("t1_count", 34'(out_count), 34'd10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_drained", 34'(fifo_level), 34'd0);

    // 2: partial flush
    do_reset();
    send_rec(3'd5, 1'b0);
    send_rec(3'd6, 1'b0);
    send_rec(3'd7, 1'b0);
    chk("t2_buf", 34'(dct_buffer), 34'h1F5);
    sb.push_back({4'd3, 30'h1F5});
    out_ready   = 1'b1;
    test_ending = 1'b1;
    tick();
    idle_inputs();
    wait_ended("t2_ended", 20);
    chk("t2_level", 34'(fifo_level), 34'd0);
    send_rec(3'd2, 1'b0);
    send_rec(3'd3, 1'b1);
    chk("t2_cnt_ignored", 34'(dct_count), 34'd0);
    chk("t2_still_ended", 34'(test_has_ended), 34'd1);

    // 3: overflow
    do_reset();
    for (int w = 0; w < 5; w++) begin
      send_word(w);
      if (w < 4) sb.push_back({4'd10, word_of(w)});
      if (w == 3) chk("t3_no_ovf_yet", 34'(overflow), 34'd0);
    end
    chk("t3_level", 34'(fifo_level), 34'd4);
    chk("t3_ovf", 34'(overflow), 34'd1);
    chk("t3_cnt_clr", 34'(dct_count), 34'd0);
    out_ready = 1'b1;
    wait_empty("t3_drain", 20);
    out_ready = 1'b0;
    chk("t3_sb_empty", 34'(sb.size()), 34'd0);
    chk("t3_ovf_sticky", 34'(overflow), 34'd1);

    // 4: full FIFO with simultaneous pop
    do_reset();
    for (int w = 0; w < 4; w++) begin
      send_word(w + 3);
      sb.push_back({4'd10, word_of(w + 3)});
    end
    chk("t4_full", 34'(fifo_level), 34'd4);
    for (int i = 0; i < 9; i++) send_rec(3'((7 + i) % 8), 1'b0);
    sb.push_back({4'd10, word_of(7)});
    out_ready = 1'b1;
    send_rec(3'((7 + 9) % 8), 1'b0);
    out_ready = 1'b0;
    chk("t4_level", 34'(fifo_level), 34'd4);
    chk("t4_ovf", 34'(overflow), 34'd0);
    out_ready = 1'b1;
    wait_empty("t4_drain", 20);
    out_ready = 1'b0;
    chk("t4_sb_empty", 34'(sb.size()), 34'd0);

    // 5: last record of a word coincides with test_ending
    do_reset();
    for (int i = 0; i < 9; i++) send_rec(3'((2 + i) % 8), 1'b0);
    sb.push_back({4'd10, word_of(2)});
    send_rec(3'((2 + 9) % 8), 1'b1);
    chk("t5_level", 34'(fifo_level), 34'd1);
    chk("t5_count", 34'(out_count), 34'd10);
    chk("t5_cnt_clr", 34'(dct_count), 34'd0);
    tick();
    chk("t5_flush_none", 34'(fifo_level), 34'd1);
    chk("t5_not_ended", 34'(test_has_ended), 34'd0);
    out_ready = 1'b1;
    wait_ended("t5_ended", 20);
    out_ready = 1'b0;
    chk("t5_sb_empty", 34'(sb.size()), 34'd0);

    // 6: reset during drain
    do_reset();
    send_word(1);
    send_word(4);
    test_ending = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    chk("t6_level", 34'(fifo_level), 34'd2);
    chk("t6_not_ended", 34'(test_has_ended), 34'd0);
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero("t6_async");
    sb.delete();
    tick();
    reset = 1'b0;
    tick();
    send_rec(3'd6, 1'b0);
    chk("t6_run_accepts", 34'(dct_count), 34'd1);
    chk("t6_fifo_empty", 34'(fifo_level), 34'd0);
    for (int i = 1; i < 10; i++) send_rec(3'((6 + i) % 8), 1'b0);
    sb.push_back({4'd10, word_of(6)});
    chk("t6_level_after", 34'(fifo_level), 34'd1);
    out_ready = 1'b1;
    wait_empty("t6_drain", 20);
    out_ready = 1'b0;
    chk("t6_sb_empty", 34'(sb.size()), 34'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nios2_oci_trace_packer.md
Name: nios2_oci_trace_packer

Overview:
- Parametrised successor to the OCI data-capture trace test-bench hook.
- Packs narrow trace records from the OCI capture logic into fixed-width buffer words and queues completed words in a small FIFO.
- Drains the FIFO to a simulation or debug sink over a valid/ready handshake.
- On test end, flushes any partial word, drains the FIFO, then reports completion.

Parameters:
- REC_W, 3: bits per trace record.
- RECS, 10: records per buffer word. BUF_W = REC_W*RECS, 30 at defaults.
- CNT_W, 4: width of record counts; must satisfy 2^CNT_W > RECS.
- FIFO_DEPTH, 4: output FIFO entries, power of two, at least 2.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- rec_valid  in  1  trace record present this cycle.
- rec_data  in  REC_W  trace record.
- test_ending  in  1  single-cycle pulse: stop capture, flush.
- out_ready  in  1  sink accepts out_data this cycle.
- dct_buffer  out  BUF_W  current partial word being packed.
- dct_count  out  CNT_W  records held in dct_buffer.
- out_valid  out  1  FIFO head valid.
- out_data  out  BUF_W  FIFO head word.
- out_count  out  CNT_W  records valid in out_data (RECS, or fewer for a flushed partial word).
- fifo_level  out  log2(FIFO_DEPTH)+1  occupied entries.
- overflow  out  1  sticky: at least one word dropped.
- test_has_ended  out  1  sticky: flush and drain complete.

Behaviour:
- Reset values: all outputs 0; FIFO empty; state RUN.
- Reset is asynchronous and may assert at any point, including mid-flush; all state is discarded.
- Packing: an accepted record k (k = dct_count) is written to dct_buffer[k*REC_W +: REC_W]. dct_count increments; higher bits are unchanged.
- Word complete: when a record is accepted with dct_count == RECS-1, the full word (including that record) is pushed that cycle with out_count = RECS.
  - dct_buffer clears to 0 and dct_count to 0 next cycle.
  - Capture continues with no bubble.
- FIFO push latency: the pushed word appears at out_valid/out_data on the next cycle if the FIFO was empty. FIFO ordering is first-in, first-out.
- Pop: occurs when out_valid && out_ready.
- Simultaneous push and pop:
  - Allowed at any level, including full; level is unchanged.
  - If full with pop that cycle, the push succeeds.
- Full FIFO with no pop at push: the word is dropped and overflow is set (sticky). Packing counters still clear.
- out_data and out_count are held stable while out_valid && !out_ready.
- State machine RUN -> FLUSH -> DRAIN -> ENDED:
  - RUN: records accepted. test_ending -> FLUSH. A record in the same cycle as test_ending is accepted first and included in the flush.
  - FLUSH, one cycle:
    - If dct_count > 0, push the partial word with out_count = dct_count, then clear.
    - If dct_count == 0, push nothing.
    - The full-FIFO drop rule applies.
    - Go to DRAIN.
  - DRAIN: rec_valid is ignored. When fifo_level == 0, go to ENDED.
  - ENDED: test_has_ended = 1 until reset; rec_valid and test_ending are ignored.
- test_ending in FLUSH, DRAIN or ENDED is ignored.
- rec_data bits are never interpreted; X on rec_data while rec_valid is low must not propagate.

Test Plan:
1. Fill a word: reset, then 10 consecutive records 0..7,0,1 (values mod 8).
   - One push: out_data = 30'o1076543210, out_count = 10.
   - dct_count returns to 0 the cycle after the 10th record.
2. Partial flush: 3 records (5,6,7), then test_ending pulse with out_ready = 1.
   - Word 0x1F5 is pushed with out_count = 3.
   - test_has_ended rises when fifo_level reaches 0.
   - Further records leave dct_count at 0.
3. Overflow: out_ready = 0, push 5 full words.
   - fifo_level saturates at 4 and overflow = 1.
   - With out_ready = 1, the 4 oldest words drain in order.
4. Full with simultaneous pop: FIFO full, and a word completes in the same cycle as out_ready = 1.
   - Level stays 4; overflow stays 0.
5. Edge record: record accepted in the same cycle as test_ending when dct_count = 9.
   - A full word is pushed with out_count = 10.
   - FLUSH pushes nothing; test_has_ended follows the drain.
6. Reset mid-drain: assert reset during DRAIN with 2 words queued.
   - All outputs are 0 immediately (asynchronous).
   - After release, the block is in RUN with an empty FIFO.
